// File: rtl/term_writer_if.sv
// Byte stream in from the UART receiver and write bus out to the video RAM.
interface term_writer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    // Upstream producer and video RAM side.
    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    // The terminal writer itself.
    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/term_writer.sv
// Character terminal writer: turns a received byte stream into video RAM writes.
// Printable bytes are written at the cursor and advance it, CR/LF/BS move it,
// and FF blanks the whole screen one cell per cycle. The screen wraps to the
// top instead of scrolling.
module term_writer #(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 24,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic             clk,
    input  logic             rst,
    term_writer_if.slave     bus,
    output logic [9:0]       cursor_addr,
    output logic             busy
);

    localparam logic [4:0] LAST_COL  = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [9:0] LAST_ADDR = 10'(ROWS * COLS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t     state;
    logic [9:0] clr_cnt;
    logic [4:0] row;
    logic [4:0] col;
    logic       wr_en_q;
    logic [9:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       printable;

    assign bus.rx_ready = (state == IDLE) && !rst;
    assign busy         = (state == CLEAR);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cursor_addr  = {row, col};
    assign printable    = (bus.rx_data >= 8'h20) && (bus.rx_data <= 8'h7E);

    // Clear sweep and byte interpretation; the write strobe lasts one cycle
    // unless the next cycle produces another write. The clear leaves CLEAR
    // only once the final blank write is already on the bus, so rx_ready
    // rises the cycle after the last strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            row       <= '0;
            col       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                CLEAR: begin
                    if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                        row     <= '0;
                        col     <= '0;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= clr_cnt;
                        wr_data_q <= BLANK;
                        if (clr_cnt != LAST_ADDR) begin
                            clr_cnt <= clr_cnt + 10'd1;
                        end
                    end
                end
                IDLE: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_data)
                            8'h0D: begin
                                col <= '0;
                            end
                            8'h0A: begin
                                row <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
                            end
                            8'h08: begin
                                if (col != 5'd0) begin
                                    col       <= col - 5'd1;
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= {row, col - 5'd1};
                                    wr_data_q <= BLANK;
                                end
                            end
                            8'h0C: begin
                                state   <= CLEAR;
                                clr_cnt <= '0;
                                row     <= '0;
                                col     <= '0;
                            end
                            default: begin
                                if (printable) begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= {row, col};
                                    wr_data_q <= bus.rx_data;
                                    if (col == LAST_COL) begin
                                        col <= '0;
                                        row <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
                                    end else begin
                                        col <= col + 5'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: reset clear, printable writes, control
// characters, cursor wrap, backspace edges and reset during a clear.
module tb_term_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] cursor_addr;
    logic       busy;
    int         errors = 0;
    int         checks = 0;

    term_writer_if tw_if ();

    term_writer #(
        .COLS  (32),
        .ROWS  (24),
        .BLANK (8'h20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (tw_if),
        .cursor_addr (cursor_addr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte for exactly one cycle.
    task automatic applyStimulus(input logic [7:0] b);
        tw_if.rx_valid = 1'b1;
        tw_if.rx_data  = b;
        tick();
        tw_if.rx_valid = 1'b0;
        tw_if.rx_data  = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full 768-cell clear, one write per cycle, then idle with cursor home.
    task automatic checkFullClear(input string tag);
        for (int i = 0; i < 768; i++) begin
            tick();
            checkOutput(tag, {11'd0, busy, tw_if.rx_ready, tw_if.wr_en, tw_if.wr_data, tw_if.wr_addr},
                        {11'd0, 1'b1, 1'b0, 1'b1, 8'h20, 10'(i)});
        end
        tick();
        checkOutput({tag, "_end"}, {28'd0, busy, tw_if.rx_ready, tw_if.wr_en, 1'b0}, {28'd0, 4'b0100});
        checkOutput({tag, "_cur"}, 32'(cursor_addr), 32'd0);
    endtask

    initial begin
        tw_if.rx_valid = 1'b0;
        tw_if.rx_data  = 8'h00;

        // Reset state
        tick();
        tick();
        checkOutput("rst_wr_en", 32'(tw_if.wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(tw_if.wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(tw_if.wr_data), 32'd0);
        checkOutput("rst_cursor", 32'(cursor_addr), 32'd0);
        checkOutput("rst_ready", 32'(tw_if.rx_ready), 32'd0);

        // Power-up clear
        rst = 1'b0;
        checkFullClear("clr0");

        // "AB" back to back
        tw_if.rx_valid = 1'b1;
        tw_if.rx_data  = 8'h41;
        tick();
        checkOutput("A_write", {tw_if.wr_en, 13'd0, tw_if.wr_data, tw_if.wr_addr}, {1'b1, 13'd0, 8'h41, 10'd0});
        checkOutput("A_cur", 32'(cursor_addr), 32'd1);
        tw_if.rx_data = 8'h42;
        tick();
        checkOutput("B_write", {tw_if.wr_en, 13'd0, tw_if.wr_data, tw_if.wr_addr}, {1'b1, 13'd0, 8'h42, 10'd1});
        checkOutput("B_cur", 32'(cursor_addr), 32'd2);
        tw_if.rx_valid = 1'b0;
        tick();
        checkOutput("AB_strobe_end", 32'(tw_if.wr_en), 32'd0);

        // Walk to column 31, then 'X', CR, LF
        for (int i = 0; i < 29; i++) applyStimulus(8'h61);
        checkOutput("cur31", 32'(cursor_addr), 32'd31);
        applyStimulus(8'h58);
        checkOutput("X_write", {tw_if.wr_en, 13'd0, tw_if.wr_data, tw_if.wr_addr}, {1'b1, 13'd0, 8'h58, 10'd31});
        checkOutput("X_cur", 32'(cursor_addr), 32'd32);
        applyStimulus(8'h0D);
        checkOutput("CR_nowr", 32'(tw_if.wr_en), 32'd0);
        checkOutput("CR_cur", 32'(cursor_addr), 32'd32);
        applyStimulus(8'h0A);
        checkOutput("LF_nowr", 32'(tw_if.wr_en), 32'd0);
        checkOutput("LF_cur", 32'(cursor_addr), 32'd64);

        // Walk to the last cell and wrap to the top
        for (int i = 0; i < 21; i++) applyStimulus(8'h0A);
        checkOutput("cur736", 32'(cursor_addr), 32'd736);
        for (int i = 0; i < 31; i++) applyStimulus(8'h62);
        checkOutput("cur767", 32'(cursor_addr), 32'd767);
        applyStimulus(8'h5A);
        checkOutput("Z_write", {tw_if.wr_en, 13'd0, tw_if.wr_data, tw_if.wr_addr}, {1'b1, 13'd0, 8'h5A, 10'd767});
        checkOutput("Z_cur", 32'(cursor_addr), 32'd0);

        // LF on the bottom row wraps the row only
        for (int i = 0; i < 23; i++) applyStimulus(8'h0A);
        for (int i = 0; i < 5; i++) applyStimulus(8'h63);
        checkOutput("cur741", 32'(cursor_addr), 32'd741);
        applyStimulus(8'h0A);
        checkOutput("LFwrap_nowr", 32'(tw_if.wr_en), 32'd0);
        checkOutput("LFwrap_cur", 32'(cursor_addr), 32'd5);

        // Backspace at column 1 and column 0, then ignored bytes
        applyStimulus(8'h0D);
        applyStimulus(8'h0A);
        applyStimulus(8'h0A);
        applyStimulus(8'h64);
        checkOutput("cur65", 32'(cursor_addr), 32'd65);
        applyStimulus(8'h08);
        checkOutput("BS_write", {tw_if.wr_en, 13'd0, tw_if.wr_data, tw_if.wr_addr}, {1'b1, 13'd0, 8'h20, 10'd64});
        checkOutput("BS_cur", 32'(cursor_addr), 32'd64);
        applyStimulus(8'h08);
        checkOutput("BS0_nowr", 32'(tw_if.wr_en), 32'd0);
        checkOutput("BS0_cur", 32'(cursor_addr), 32'd64);
        applyStimulus(8'h07);
        checkOutput("BEL_nowr", 32'(tw_if.wr_en), 32'd0);
        checkOutput("BEL_cur", 32'(cursor_addr), 32'd64);
        applyStimulus(8'h7F);
        checkOutput("DEL_nowr", 32'(tw_if.wr_en), 32'd0);
        applyStimulus(8'hFF);
        checkOutput("FF_byte_nowr", 32'(tw_if.wr_en), 32'd0);
        checkOutput("FF_byte_cur", 32'(cursor_addr), 32'd64);

        // Form feed, then reset after 300 clear writes
        applyStimulus(8'h0C);
        checkOutput("FF_enter", {28'd0, busy, tw_if.rx_ready, tw_if.wr_en, 1'b0}, {28'd0, 4'b1000});
        checkOutput("FF_cur", 32'(cursor_addr), 32'd0);
        for (int i = 0; i < 300; i++) begin
            tick();
            checkOutput("ffclr", {tw_if.wr_en, 13'd0, tw_if.wr_data, tw_if.wr_addr}, {1'b1, 13'd0, 8'h20, 10'(i)});
        end
        rst = 1'b1;
        tick();
        checkOutput("abort_wr_en", 32'(tw_if.wr_en), 32'd0);
        tick();
        checkOutput("abort_hold", {tw_if.wr_en, tw_if.rx_ready, 20'd0, tw_if.wr_addr}, 32'd0);
        rst = 1'b0;
        checkFullClear("clr1");

        // rx_ready drops as soon as reset is raised in idle
        rst = 1'b1;
        #1;
        checkOutput("rst_ready_comb", 32'(tw_if.rx_ready), 32'd0);
        tick();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
